// File: rtl/hilo_muldiv_pkg.sv
// Shared opcodes, FSM states and arithmetic helpers for the HI/LO multiply/divide sequencer.
package hilo_muldiv_pkg;

  localparam int DATA_W             = 32;
  localparam int DIV_ITER           = 32;
  localparam int MUL_CYCLES_DEFAULT = 3;
  localparam int CNT_W              = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  // Full 64-bit product; sign extension makes the modulo-2^64 result correct for signed operands.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    bx = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step on a 64-bit remainder/quotient register.
module div_core
  import hilo_muldiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [63:0]       rq_reg;
  logic [31:0]       divisor_reg;
  logic [32:0]       trial;
  logic [31:0]       diff;
  logic              fits;

  // The shifted partial remainder needs 33 bits; the difference always fits back in 32.
  always_comb begin
    trial = rq_reg[63:31];
    fits  = (trial >= {1'b0, divisor_reg});
    diff  = trial[31:0] - divisor_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rq_reg      <= '0;
      divisor_reg <= '0;
    end else if (load) begin
      rq_reg      <= {32'b0, dividend};
      divisor_reg <= divisor;
    end else if (step) begin
      if (fits) begin
        rq_reg <= {diff, rq_reg[30:0], 1'b1};
      end else begin
        rq_reg <= {rq_reg[62:0], 1'b0};
      end
    end
  end

  assign quotient  = rq_reg[31:0];
  assign remainder = rq_reg[63:32];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer with pipeline stall; define HILO_WRITE_EN to add mthi/mtlo write ports.
module hilo_muldiv_ctrl
  import hilo_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hilo_rd_req,
`ifdef HILO_WRITE_EN
  input  logic [1:0]  mt_we,
  input  logic [31:0] mt_data,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        hi_reg;
  logic [31:0]        lo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic               sign_q_reg;
  logic               sign_r_reg;

  logic               accept;
  logic               accept_mul;
  logic               accept_div;
  logic               div_signed;
  logic               div_step;
  logic [31:0]        div_dividend;
  logic [31:0]        div_divisor;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic [63:0]        mul_result;

  always_comb begin
    accept       = (state_reg == ST_IDLE) && start;
    accept_div   = accept && op[1];
    accept_mul   = accept && !op[1];
    div_signed   = (op == OP_DIV);
    div_step     = (state_reg == ST_DIV);
    div_dividend = magnitude(operand_a, div_signed);
    div_divisor  = magnitude(operand_b, div_signed);
  end

  // Product is formed at accept and shifted one stage per cycle; the last stage feeds HI/LO.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_CYCLES; gi++) begin : g_mul_pipe
      logic [63:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clock) begin
          if (reset) begin
            stage_reg <= '0;
          end else if (accept_mul) begin
            stage_reg <= mul64(operand_a, operand_b, op == OP_MULT);
          end
        end
      end else begin : g_tail
        always_ff @(posedge clock) begin
          if (reset) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= g_mul_pipe[gi-1].stage_reg;
          end
        end
      end
    end
  endgenerate

  assign mul_result = g_mul_pipe[MUL_CYCLES-1].stage_reg;

  div_core u_div_core (
    .clock     (clock),
    .reset     (reset),
    .load      (accept_div),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg    <= operand_a;
            b_reg    <= operand_b;
            busy_reg <= 1'b1;
            if (op[1]) begin
              state_reg  <= ST_DIV;
              cnt_reg    <= CNT_W'(DIV_ITER - 1);
              sign_q_reg <= div_signed && (operand_a[31] ^ operand_b[31]);
              sign_r_reg <= div_signed && operand_a[31];
            end else begin
              state_reg  <= ST_MUL;
              cnt_reg    <= CNT_W'(MUL_CYCLES - 1);
              sign_q_reg <= 1'b0;
              sign_r_reg <= 1'b0;
            end
          end
`ifdef HILO_WRITE_EN
          else begin
            if (mt_we[1]) hi_reg <= mt_data;
            if (mt_we[0]) lo_reg <= mt_data;
          end
`endif
        end
        ST_MUL: begin
          if (cnt_reg == '0) begin
            hi_reg    <= mul_result[63:32];
            lo_reg    <= mul_result[31:0];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_DIV: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_FIX;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_FIX: begin
          // Divide by zero reports all-ones quotient and the raw dividend, independent of sign.
          if (b_reg == '0) begin
            lo_reg <= '1;
            hi_reg <= a_reg;
          end else begin
            lo_reg <= sign_q_reg ? -quo : quo;
            hi_reg <= sign_r_reg ? -rem : rem;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HILO_WRITE_EN
  assign stall = busy_reg && (start || hilo_rd_req || (mt_we != 2'b00));
`else
  assign stall = busy_reg && (start || hilo_rd_req);
`endif

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized self-checking bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hilo_rd_req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int failures = 0;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  always #5 clock = ~clock;

  hilo_muldiv_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hilo_rd_req (hilo_rd_req),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .stall       (stall)
  );

  // Reference: returns {HI, LO} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    int ia, ib, q, r;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        return sp;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        ia = a; ib = b;
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rd, output int lat, output bit busy_bad, output bit stall_bad);
    lat = 0; busy_bad = 0; stall_bad = 0;
    hilo_rd_req = rd;
    #1;
    for (int c = 0; c < 200; c++) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (rd && stall !== 1'b1) stall_bad = 1;
      @(posedge clock); #1;
      lat++;
      if (done === 1'b1) break;
    end
    hilo_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hilo_rd_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    hilo_rd_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat; bit bb, sb;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, lat, bb, sb);
    $display("txn multu a=ffffffff b=ffffffff hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL multu_lat got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (bb) begin failures++; $display("FAIL multu_busy got=low_during_op exp=high"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_done got=%b exp=0", busy); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult_neg_mfhi();
    int lat; bit bb, sb;
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(1'b0, lat, bb, sb);
    $display("txn mult a=fffffffd b=5 hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    hilo_rd_req = 1'b1;
    @(posedge clock); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mfhi_stall got=%b exp=0", stall); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mfhi_value got=%h exp=ffffffff", hi); end
    hilo_rd_req = 1'b0;
  endtask

  task automatic test_div_signed_stall();
    int lat; bit bb, sb;
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b1, lat, bb, sb);
    $display("txn div a=fffffff9 b=2 hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL div_lat got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if (sb) begin failures++; $display("FAIL div_stall got=low_during_busy exp=high"); end
    checks++; if (bb) begin failures++; $display("FAIL div_busy got=low_during_op exp=high"); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
  endtask

  task automatic test_div_edges();
    logic [1:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [63:0] exp;
    int lat; bit bb, sb;
    ops[0] = 2'b11; as[0] = 32'h12345678; bs[0] = 32'h0;
    ops[1] = 2'b10; as[1] = 32'h80000005; bs[1] = 32'h0;
    ops[2] = 2'b10; as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      issue(ops[i], as[i], bs[i]);
      wait_done(1'b0, lat, bb, sb);
      $display("txn edge op=%b a=%h b=%h hi=%h lo=%h lat=%0d", ops[i], as[i], bs[i], hi, lo, lat);
      checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL edge_lat[%0d] got=%0d exp=%0d", i, lat, DIV_LAT); end
      checks++; if (lo !== exp[31:0]) begin failures++; $display("FAIL edge_lo[%0d] got=%h exp=%h", i, lo, exp[31:0]); end
      checks++; if (hi !== exp[63:32]) begin failures++; $display("FAIL edge_hi[%0d] got=%h exp=%h", i, hi, exp[63:32]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit bb, sb; bit saw_done;
    issue(2'b10, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) saw_done = 1;
      @(posedge clock); #1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL abort_done got=pulse exp=none"); end
    issue(2'b01, 32'd6, 32'd7);
    wait_done(1'b0, lat, bb, sb);
    $display("txn multu a=6 b=7 hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL abort_mul_lo got=%h exp=%h", lo, 32'd42); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL abort_mul_hi got=%h exp=0", hi); end
  endtask

  task automatic test_start_while_busy();
    int lat; bit bb, sb; bit stall_low;
    issue(2'b10, 32'd100, 32'd7);
    stall_low = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      start = 1'b1; op = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
      #1;
      if (stall !== 1'b1) stall_low = 1;
    end
    @(negedge clock); start = 1'b0;
    checks++; if (stall_low) begin failures++; $display("FAIL busy_start_stall got=0 exp=1"); end
    wait_done(1'b0, lat, bb, sb);
    $display("txn div a=100 b=7 (multu ignored) hi=%h lo=%h", hi, lo);
    checks++; if (lat >= 200) begin failures++; $display("FAIL busy_start_timeout got=%0d exp=<200", lat); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL busy_start_lo got=%h exp=%h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL busy_start_hi got=%h exp=%h", hi, 32'd2); end
    issue(2'b01, 32'd2, 32'd3);
    wait_done(1'b0, lat, bb, sb);
    $display("txn multu a=2 b=3 hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL reissue_lo got=%h exp=6", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int lat; bit bb, sb;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    e1 = model(2'b00, a1, b1);
    e2 = model(2'b11, a2, b2);
    issue(2'b00, a1, b1);
    wait_done(1'b0, lat, bb, sb);
    start = 1'b1; op = 2'b11; operand_a = a2; operand_b = b2;
    @(posedge clock); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if ({hi, lo} !== e1) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", {hi, lo}, e1); end
    wait_done(1'b0, lat, bb, sb);
    $display("txn b2b divu a=%h b=%h hi=%h lo=%h lat=%0d", a2, b2, hi, lo, lat);
    checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if ({hi, lo} !== e2) begin failures++; $display("FAIL b2b_result got=%h exp=%h", {hi, lo}, e2); end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat, exp_lat; bit bb, sb;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      exp = model(o, a, b);
      exp_lat = o[1] ? DIV_LAT : MUL_LAT;
      issue(o, a, b);
      wait_done(1'b0, lat, bb, sb);
      $display("txn rand op=%b a=%h b=%h hi=%h lo=%h lat=%0d", o, a, b, hi, lo, lat);
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rand_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (bb) begin failures++; $display("FAIL rand_busy[%0d] got=low_during_op exp=high", i); end
      checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL rand_result[%0d] got=%h exp=%h", i, {hi, lo}, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_neg_mfhi();
    test_div_signed_stall();
    test_div_edges();
    test_reset_abort();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
